// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller around a simple dual-port BRAM (1-cycle registered read),
// with a 2-entry output buffer hiding read latency. Optional level port: BRAM_FIFO_LEVEL_EN.
module bram_fifo_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BRAM_DATA_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BRAM_DATA_WIDTH-1:0] out_data,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr,
    output logic                       bram_wr_en,
    output logic [BRAM_DATA_WIDTH-1:0] bram_din,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_dout
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    output logic [BRAM_ADDR_WIDTH+1:0] level
`endif
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = BRAM_DATA_WIDTH;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   mem_count_q, mem_count_d;
    logic          rd_pending_q, rd_pending_d;
    logic [1:0]    obuf_count_q, obuf_count_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] skid_q, skid_d;

    logic          push, pop, rd_issue;
    logic [2:0]    occ_after_pop;

    assign in_ready     = ~reset & (mem_count_q != DEPTH);
    assign push         = in_valid & in_ready;
    assign out_valid    = (obuf_count_q != 2'd0);
    assign out_data     = head_q;
    assign pop          = out_valid & out_ready;

    assign bram_wr_en   = push;
    assign bram_wr_addr = wr_ptr_q;
    assign bram_din     = in_data;
    assign bram_rd_addr = rd_ptr_q;

    // Output-buffer slots claimed after this cycle's pop; a read is issued only if one slot stays free.
    assign occ_after_pop = {1'b0, obuf_count_q} + {2'b00, rd_pending_q} - {2'b00, pop};
    assign rd_issue      = (mem_count_q != '0) & (occ_after_pop < 3'd2);

    always_comb begin
        wr_ptr_d     = wr_ptr_q + {{(AW-1){1'b0}}, push};
        rd_ptr_d     = rd_ptr_q + {{(AW-1){1'b0}}, rd_issue};
        mem_count_d  = mem_count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, rd_issue};
        rd_pending_d = rd_issue;
        head_d       = head_q;
        skid_d       = skid_q;
        obuf_count_d = obuf_count_q;
        case ({rd_pending_q, pop})
            2'b10: begin
                if (obuf_count_q == 2'd0) head_d = bram_dout;
                else                      skid_d = bram_dout;
                obuf_count_d = obuf_count_q + 2'd1;
            end
            2'b01: begin
                head_d       = skid_q;
                obuf_count_d = obuf_count_q - 2'd1;
            end
            2'b11: begin
                if (obuf_count_q == 2'd1) begin
                    head_d = bram_dout;
                end else begin
                    head_d = skid_q;
                    skid_d = bram_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_count_q  <= '0;
            rd_pending_q <= 1'b0;
            obuf_count_q <= 2'd0;
            head_q       <= '0;
            skid_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_count_q  <= mem_count_d;
            rd_pending_q <= rd_pending_d;
            obuf_count_q <= obuf_count_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
        end
    end

`ifdef BRAM_FIFO_LEVEL_EN
    logic [AW+1:0] level_q, level_d;

    assign level_d = {1'b0, mem_count_d} + {{(AW+1){1'b0}}, rd_pending_d}
                   + {{AW{1'b0}}, obuf_count_d};

    always_ff @(posedge clock) begin
        if (reset) level_q <= '0;
        else       level_q <= level_d;
    end

    assign level = level_q;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a behavioural BRAM (registered read, read-old-data)
// and an in-order scoreboard that also checks output stability under stall.
module tb_bram_fifo_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] bram_wr_addr;
    logic          bram_wr_en;
    logic [DW-1:0] bram_din;
    logic [AW-1:0] bram_rd_addr;
    logic [DW-1:0] bram_dout;
`ifdef BRAM_FIFO_LEVEL_EN
    logic [AW+1:0] level;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bram_fifo_ctrl #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bram_wr_addr(bram_wr_addr), .bram_wr_en(bram_wr_en), .bram_din(bram_din),
        .bram_rd_addr(bram_rd_addr), .bram_dout(bram_dout)
`ifdef BRAM_FIFO_LEVEL_EN
        , .level(level)
`endif
    );

    logic [DW-1:0] mem [1<<AW];
    always @(posedge clock) begin
        if (bram_wr_en) mem[bram_wr_addr] <= bram_din;
        bram_dout <= mem[bram_rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: order of popped words and hold-stable while stalled.
    logic [DW-1:0] sbq[$];
    initial begin : monitor
        logic          stall;
        logic [DW-1:0] stall_data;
        logic [DW-1:0] exp_word;
        stall = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                sbq.delete();
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_data", {24'd0, out_data}, {24'd0, stall_data});
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("sb_unexpected_pop", 32'd1, 32'd0);
                    end else begin
                        exp_word = sbq.pop_front();
                        chk("sb_order", {24'd0, out_data}, {24'd0, exp_word});
                    end
                end
                if (in_valid && in_ready) sbq.push_back(in_data);
                stall      = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    end

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [DW-1:0] d;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic [AW-1:0] e_ra;
    } vec_t;

    vec_t tbl[13];

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int sent, rcv, first, bub, acc, stale;
        bit done;

        // iv ordy data   ir ov  od     we wa ra
        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 4'd1};
        tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 4'd1, 4'd1};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 4'd1};
        tbl[5]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 4'd1, 4'd1};
        tbl[6]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 8'h00, 1'b1, 4'd2, 4'd1};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd3, 4'd2};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 4'd3, 4'd3};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 4'd3, 4'd3};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 4'd3, 4'd3};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 4'd3, 4'd3};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd3, 4'd3};

        // Reset and idle
        reset = 1'b1;
        @(negedge clock);
        chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_wr_en", {31'd0, bram_wr_en}, 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
        chk("rst_level", {26'd0, level}, 32'd0);
`endif
        step();

        // Directed vectors: single-word latency, then a stalled two-word sequence
        for (int i = 0; i < 13; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            in_data   = tbl[i].d;
            @(negedge clock);
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            if (tbl[i].e_ov)
                chk($sformatf("v%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].e_od});
            chk($sformatf("v%0d_wr_en", i), {31'd0, bram_wr_en}, {31'd0, tbl[i].e_we});
            chk($sformatf("v%0d_wr_addr", i), {28'd0, bram_wr_addr}, {28'd0, tbl[i].e_wa});
            chk($sformatf("v%0d_rd_addr", i), {28'd0, bram_rd_addr}, {28'd0, tbl[i].e_ra});
            step();
        end
        in_valid = 1'b0;

        // Full-rate stream of 0..255
        sent = 0; rcv = 0; first = -1; bub = 0;
        for (int k = 0; k < 300 && rcv < 256; k++) begin
            in_valid  = (sent < 256);
            in_data   = sent[7:0];
            out_ready = 1'b1;
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                if (first < 0) first = k;
                rcv++;
            end else if (rcv > 0) begin
                bub++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("stream_first_out_cycle", first, 32'd3);
        chk("stream_received", rcv, 32'd256);
        chk("stream_bubbles", bub, 32'd0);

        // Fill to capacity with output stalled
        acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h80 + acc[7:0];
            @(negedge clock);
            if (!in_ready) break;
            acc++;
            step();
        end
        step();
        in_valid = 1'b0;
        chk("capacity", acc, 32'd18);
        out_ready = 1'b1;
        @(negedge clock);
        chk("full_in_ready_at_release", {31'd0, in_ready}, 32'd0);
        step();
        @(negedge clock);
        chk("in_ready_after_first_issue", {31'd0, in_ready}, 32'd1);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            @(negedge clock);
            done = (sbq.size() == 0) && !out_valid;
        end
        chk("capacity_drained", {31'd0, done}, 32'd1);
        step();

        // Random traffic
        for (int k = 0; k < 5000; k++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 1) == 1;
            in_data   = 8'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            step();
            @(negedge clock);
            done = (sbq.size() == 0) && !out_valid;
        end
        chk("random_drained", {31'd0, done}, 32'd1);
        step();

        // Reset with words queued and a read in flight
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hC0 + 8'(k);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        stale = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clock);
            if (out_valid) stale++;
        end
        chk("midrst_stale_words", stale, 32'd0);
        step();
        in_valid = 1'b1;
        in_data  = 8'h5C;
        @(negedge clock);
        chk("midrst_wr_en", {31'd0, bram_wr_en}, 32'd1);
        chk("midrst_wr_addr", {28'd0, bram_wr_addr}, 32'd0);
        chk("midrst_rd_addr", {28'd0, bram_rd_addr}, 32'd0);
        step();
        in_valid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clock);
            done = out_valid;
            if (!done) step();
        end
        chk("midrst_new_word_valid", {31'd0, done}, 32'd1);
        chk("midrst_new_word_data", {24'd0, out_data}, 32'h5C);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
